// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage between EX/MEM and MEM/WB: loads, stores and LL/SC over a req/ack data bus.
// Latency: non-memory ops and failed SC pass through combinationally; bus accesses take the request cycle(s) plus one DONE cycle.
// Backpressure: stallreq is held high from the first request cycle until ack, and the bus may stall indefinitely.
// Ports:
//   ex_*            EX/MEM register outputs (held stable while stallreq is high)
//   LLbit_i, wb_*   stored LLbit and a pending WB-stage LLbit write
//   bus_*           single-master data bus, big-endian lanes (bus_sel[3] = data[31:24])
//   mem_*           writeback bundle for MEM/WB; stallreq to the stall controller
module mem_access_stage #(
    parameter bit LLBIT_FWD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic        ex_whilo,
    input  logic [3:0]  ex_memop,
    input  logic [31:0] ex_memaddr,
    input  logic [31:0] ex_storedata,
    input  logic        LLbit_i,
    input  logic        wb_LLbit_we,
    input  logic        wb_LLbit_value,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_whilo,
    output logic        mem_LLbit_we,
    output logic        mem_LLbit_value,
    output logic        stallreq
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [3:0] OP_LL  = 4'd9;
    localparam logic [3:0] OP_SC  = 4'd10;

    state_t      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;

    logic        eff_llbit;
    logic        is_access;
    logic        is_store;
    logic [3:0]  lane_sel;
    logic [31:0] store_dat;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] done_wdata;

    // A pending WB-stage LLbit write is newer than the stored copy.
    assign eff_llbit = (LLBIT_FWD && wb_LLbit_we) ? wb_LLbit_value : LLbit_i;

    // Operation decode: whether a bus cycle is needed, direction, lanes and lane-replicated store data.
    always_comb begin
        is_access = 1'b0;
        is_store  = 1'b0;
        lane_sel  = 4'b0000;
        store_dat = ex_storedata;
        case (ex_memop)
            OP_LB, OP_LBU: begin
                is_access = 1'b1;
                lane_sel  = 4'b1000 >> ex_memaddr[1:0];
            end
            OP_LH, OP_LHU: begin
                is_access = 1'b1;
                lane_sel  = ex_memaddr[1] ? 4'b0011 : 4'b1100;
            end
            OP_LW, OP_LL: begin
                is_access = 1'b1;
                lane_sel  = 4'b1111;
            end
            OP_SB: begin
                is_access = 1'b1;
                is_store  = 1'b1;
                lane_sel  = 4'b1000 >> ex_memaddr[1:0];
                store_dat = {4{ex_storedata[7:0]}};
            end
            OP_SH: begin
                is_access = 1'b1;
                is_store  = 1'b1;
                lane_sel  = ex_memaddr[1] ? 4'b0011 : 4'b1100;
                store_dat = {2{ex_storedata[15:0]}};
            end
            OP_SW: begin
                is_access = 1'b1;
                is_store  = 1'b1;
                lane_sel  = 4'b1111;
            end
            OP_SC: begin
                // A failed SC never touches the bus.
                is_access = eff_llbit;
                is_store  = 1'b1;
                lane_sel  = 4'b1111;
            end
            default: ;
        endcase
    end

    // Lane extraction from the captured read word (big-endian: address 0 is bits [31:24]).
    always_comb begin
        case (ex_memaddr[1:0])
            2'b00:   lane_b = rdata_q[31:24];
            2'b01:   lane_b = rdata_q[23:16];
            2'b10:   lane_b = rdata_q[15:8];
            default: lane_b = rdata_q[7:0];
        endcase
        lane_h = ex_memaddr[1] ? rdata_q[15:0] : rdata_q[31:16];
    end

    // Writeback data for the DONE cycle.
    always_comb begin
        case (ex_memop)
            OP_LB:        done_wdata = {{24{lane_b[7]}}, lane_b};
            OP_LBU:       done_wdata = {24'd0, lane_b};
            OP_LH:        done_wdata = {{16{lane_h[15]}}, lane_h};
            OP_LHU:       done_wdata = {16'd0, lane_h};
            OP_LW, OP_LL: done_wdata = rdata_q;
            OP_SC:        done_wdata = 32'd1;
            default:      done_wdata = ex_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        rdata_d         = rdata_q;
        bus_req         = 1'b0;
        bus_we          = 1'b0;
        bus_addr        = 32'd0;
        bus_sel         = 4'b0000;
        bus_wdata       = 32'd0;
        mem_wd          = 5'd0;
        mem_wreg        = 1'b0;
        mem_wdata       = 32'd0;
        mem_hi          = 32'd0;
        mem_lo          = 32'd0;
        mem_whilo       = 1'b0;
        mem_LLbit_we    = 1'b0;
        mem_LLbit_value = 1'b0;
        stallreq        = 1'b0;

        if (rst) begin
            state_d = S_IDLE;
        end else begin
            // Data fields always follow EX; the enables below decide whether they matter.
            mem_wd    = ex_wd;
            mem_hi    = ex_hi;
            mem_lo    = ex_lo;
            mem_wdata = ex_wdata;

            case (state_q)
                S_IDLE: begin
                    if (is_access) begin
                        bus_req = 1'b1;
                        if (bus_ack) begin
                            rdata_d = bus_rdata;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else begin
                        mem_wreg  = ex_wreg;
                        mem_whilo = ex_whilo;
                        if (ex_memop == OP_SC) begin
                            mem_wdata = 32'd0;
                        end
                    end
                end
                S_WAIT: begin
                    bus_req = 1'b1;
                    if (bus_ack) begin
                        rdata_d = bus_rdata;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    mem_wreg  = ex_wreg;
                    mem_whilo = ex_whilo;
                    mem_wdata = done_wdata;
                    if (ex_memop == OP_LL) begin
                        mem_LLbit_we    = 1'b1;
                        mem_LLbit_value = 1'b1;
                    end else if (ex_memop == OP_SC) begin
                        mem_LLbit_we    = 1'b1;
                        mem_LLbit_value = 1'b0;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            stallreq = bus_req;
            if (bus_req) begin
                bus_we    = is_store;
                bus_addr  = {ex_memaddr[31:2], 2'b00};
                bus_sel   = lane_sel;
                bus_wdata = is_store ? store_dat : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata, ex_hi, ex_lo;
    logic        ex_whilo;
    logic [3:0]  ex_memop;
    logic [31:0] ex_memaddr, ex_storedata;
    logic        LLbit_i, wb_LLbit_we, wb_LLbit_value;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_sel;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic        mem_whilo, mem_LLbit_we, mem_LLbit_value, stallreq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.LLBIT_FWD(1'b1)) dut (
        .clk(clk), .rst(rst),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .ex_memop(ex_memop), .ex_memaddr(ex_memaddr), .ex_storedata(ex_storedata),
        .LLbit_i(LLbit_i), .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_sel(bus_sel), .bus_wdata(bus_wdata),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .mem_LLbit_we(mem_LLbit_we), .mem_LLbit_value(mem_LLbit_value),
        .stallreq(stallreq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [31:0] wdata;
        logic        wreg;
        logic        whilo;
        logic        llbit;
        logic        wbwe;
        logic        wbval;
        logic        e_req;
        logic        e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_addr;
        logic [31:0] e_bwd;
        logic [31:0] e_mwd;
        logic        e_llwe;
        logic        e_llval;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic idle_inputs();
        ex_wd = 5'd0; ex_wreg = 1'b0; ex_wdata = 32'd0; ex_hi = 32'd0; ex_lo = 32'd0;
        ex_whilo = 1'b0; ex_memop = 4'd0; ex_memaddr = 32'd0; ex_storedata = 32'd0;
        LLbit_i = 1'b0; wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0;
        bus_rdata = 32'd0; bus_ack = 1'b0;
    endtask

    initial begin
        //            op     addr          sdata         rdata         wdata         wr    hl    ll    wbwe  wbv   req   we    sel      baddr         bwdata        mwdata        llwe  llv
        vecs[0]  = '{4'd1,  32'h0000_0103, 32'h0,        32'h12F4_5680, 32'h0,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 32'h0000_0100, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0};
        vecs[1]  = '{4'd2,  32'h0000_0101, 32'h0,        32'h12F4_5680, 32'h0,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 32'h0000_0100, 32'h0,        32'h0000_00F4, 1'b0, 1'b0};
        vecs[2]  = '{4'd3,  32'h0000_0103, 32'h0,        32'h7FFF_8001, 32'h0,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 32'h0000_0100, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0};
        vecs[3]  = '{4'd4,  32'h0000_0100, 32'h0,        32'h9ABC_1234, 32'h0,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1100, 32'h0000_0100, 32'h0,        32'h0000_9ABC, 1'b0, 1'b0};
        vecs[4]  = '{4'd5,  32'h0000_0207, 32'h0,        32'h89AB_CDEF, 32'h0,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_0204, 32'h0,        32'h89AB_CDEF, 1'b0, 1'b0};
        vecs[5]  = '{4'd6,  32'h0000_0301, 32'h1234_56EF, 32'hFFFF_FFFF, 32'h5,      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0100, 32'h0000_0300, 32'hEFEF_EFEF, 32'h0000_0005, 1'b0, 1'b0};
        vecs[6]  = '{4'd7,  32'h0000_0202, 32'h0000_ABCD, 32'h0,        32'h77,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h0000_0200, 32'hABCD_ABCD, 32'h0000_0077, 1'b0, 1'b0};
        vecs[7]  = '{4'd8,  32'h0000_040E, 32'hCAFE_F00D, 32'h0,        32'h9,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 32'h0000_040C, 32'hCAFE_F00D, 32'h0000_0009, 1'b0, 1'b0};
        vecs[8]  = '{4'd9,  32'h0000_0500, 32'h0,        32'h0102_0304, 32'h0,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_0500, 32'h0,        32'h0102_0304, 1'b1, 1'b1};
        vecs[9]  = '{4'd10, 32'h0000_0500, 32'h1111_1111, 32'h0,        32'h0,       1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 32'h0000_0500, 32'h1111_1111, 32'h0000_0001, 1'b1, 1'b0};
        vecs[10] = '{4'd10, 32'h0000_0500, 32'h1111_1111, 32'h0,        32'h33,      1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,        32'h0,         1'b0, 1'b0};
        vecs[11] = '{4'd10, 32'h0000_0504, 32'h2222_2222, 32'h0,        32'h0,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 32'h0000_0504, 32'h2222_2222, 32'h0000_0001, 1'b1, 1'b0};
        vecs[12] = '{4'd0,  32'h0,         32'h0,        32'h0,        32'h55,      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,        32'h0000_0055, 1'b0, 1'b0};
        vecs[13] = '{4'd13, 32'h0000_0123, 32'h0000_FFFF, 32'h0,        32'hA5,      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,        32'h0000_00A5, 1'b0, 1'b0};

        // Reset: outputs forced to zero even with a load and ack presented.
        idle_inputs();
        rst = 1'b1;
        ex_memop = 4'd5; ex_memaddr = 32'h100; ex_wreg = 1'b1; ex_wd = 5'd3;
        ex_wdata = 32'h1234; ex_hi = 32'h77; bus_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bus_req",  {31'd0, bus_req},  32'd0);
        check("rst_stallreq", {31'd0, stallreq}, 32'd0);
        check("rst_mem_wreg", {31'd0, mem_wreg}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wd",   {27'd0, mem_wd},   32'd0);
        check("rst_mem_hi",   mem_hi, 32'd0);
        check("rst_bus_sel",  {28'd0, bus_sel},  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();

        // Table-driven single transactions, ack in the request cycle.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            ex_memop = vecs[i].op; ex_memaddr = vecs[i].addr; ex_storedata = vecs[i].sdata;
            ex_wdata = vecs[i].wdata; ex_wreg = vecs[i].wreg; ex_whilo = vecs[i].whilo;
            ex_wd = 5'(i + 1); ex_hi = 32'h1000_0000 + i; ex_lo = 32'h2000_0000 + i;
            LLbit_i = vecs[i].llbit; wb_LLbit_we = vecs[i].wbwe; wb_LLbit_value = vecs[i].wbval;
            bus_rdata = vecs[i].rdata; bus_ack = vecs[i].e_req;
            @(negedge clk);
            check($sformatf("v%0d_req", i),   {31'd0, bus_req},  {31'd0, vecs[i].e_req});
            check($sformatf("v%0d_stall", i), {31'd0, stallreq}, {31'd0, vecs[i].e_req});
            check($sformatf("v%0d_we", i),    {31'd0, bus_we},   {31'd0, vecs[i].e_we});
            check($sformatf("v%0d_sel", i),   {28'd0, bus_sel},  {28'd0, vecs[i].e_sel});
            check($sformatf("v%0d_baddr", i), bus_addr,  vecs[i].e_addr);
            check($sformatf("v%0d_bwdata", i), bus_wdata, vecs[i].e_bwd);
            check($sformatf("v%0d_llwe0", i), {31'd0, mem_LLbit_we}, 32'd0);
            if (vecs[i].e_req) begin
                check($sformatf("v%0d_gate_wreg", i),  {31'd0, mem_wreg},  32'd0);
                check($sformatf("v%0d_gate_whilo", i), {31'd0, mem_whilo}, 32'd0);
                @(posedge clk); #1;
                bus_ack = 1'b0; bus_rdata = 32'hDEAD_0000;
                @(negedge clk);
                check($sformatf("v%0d_done_req", i),   {31'd0, bus_req},  32'd0);
                check($sformatf("v%0d_done_stall", i), {31'd0, stallreq}, 32'd0);
                check($sformatf("v%0d_done_sel", i),   {28'd0, bus_sel},  32'd0);
            end
            check($sformatf("v%0d_mwdata", i), mem_wdata, vecs[i].e_mwd);
            check($sformatf("v%0d_mwreg", i),  {31'd0, mem_wreg},  {31'd0, vecs[i].wreg});
            check($sformatf("v%0d_mwhilo", i), {31'd0, mem_whilo}, {31'd0, vecs[i].whilo});
            check($sformatf("v%0d_mwd", i),    {27'd0, mem_wd},    32'(i + 1));
            check($sformatf("v%0d_mhi", i),    mem_hi, 32'h1000_0000 + i);
            check($sformatf("v%0d_mlo", i),    mem_lo, 32'h2000_0000 + i);
            check($sformatf("v%0d_llwe", i),   {31'd0, mem_LLbit_we},    {31'd0, vecs[i].e_llwe});
            check($sformatf("v%0d_llval", i),  {31'd0, mem_LLbit_value}, {31'd0, vecs[i].e_llval});
        end

        // LW with ack on the third request cycle.
        @(posedge clk); #1;
        idle_inputs();
        ex_memop = 4'd5; ex_memaddr = 32'h100; ex_wreg = 1'b1; ex_wd = 5'd7;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            check($sformatf("lw3_req_c%0d", c),   {31'd0, bus_req},  32'd1);
            check($sformatf("lw3_stall_c%0d", c), {31'd0, stallreq}, 32'd1);
            check($sformatf("lw3_sel_c%0d", c),   {28'd0, bus_sel},  32'hF);
            check($sformatf("lw3_addr_c%0d", c),  bus_addr, 32'h100);
            @(posedge clk); #1;
        end
        bus_ack = 1'b0; bus_rdata = 32'd0;
        @(negedge clk);
        check("lw3_done_req",   {31'd0, bus_req},  32'd0);
        check("lw3_done_stall", {31'd0, stallreq}, 32'd0);
        check("lw3_done_wreg",  {31'd0, mem_wreg}, 32'd1);
        check("lw3_done_wdata", mem_wdata, 32'hDEAD_BEEF);

        // Reset while waiting on the bus, then a late ack in IDLE, then a normal LW.
        @(posedge clk); #1;
        ex_memop = 4'd5; ex_memaddr = 32'h600; bus_ack = 1'b0;
        @(negedge clk);
        check("rw_req_idle", {31'd0, bus_req}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("rw_req_wait", {31'd0, bus_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rw_rst_req",   {31'd0, bus_req},  32'd0);
        check("rw_rst_stall", {31'd0, stallreq}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ex_memop = 4'd0; ex_wdata = 32'h66; ex_wreg = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'h0000_0BAD;
        @(negedge clk);
        check("rw_after_req",   {31'd0, bus_req},  32'd0);
        check("rw_after_stall", {31'd0, stallreq}, 32'd0);
        check("rw_after_wdata", mem_wdata, 32'h66);
        @(posedge clk); #1;
        ex_memop = 4'd5; ex_memaddr = 32'h604; bus_ack = 1'b0; bus_rdata = 32'd0;
        @(negedge clk);
        check("rw_lw_req", {31'd0, bus_req}, 32'd1);
        @(posedge clk); #1;
        check("rw_lw_wait", {31'd0, bus_req}, 32'd1);
        bus_ack = 1'b1; bus_rdata = 32'hC0DE_0001;
        @(negedge clk);
        check("rw_lw_ackcyc", {31'd0, bus_req}, 32'd1);
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_rdata = 32'd0;
        @(negedge clk);
        check("rw_lw_done_req",   {31'd0, bus_req},  32'd0);
        check("rw_lw_done_wdata", mem_wdata, 32'hC0DE_0001);
        check("rw_lw_done_wreg",  {31'd0, mem_wreg}, 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
